// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared definitions for the MIPS MEM stage.
//   WB_* : write-back select codes carried on iMemToReg (11 aliases ALU).
//   state_t : MEM-stage access FSM states.
//   wb_mux : write-back data selector used ahead of the MEM/WB register.
package mem_stage_pkg;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  function automatic logic [31:0] wb_mux(input logic [1:0]  sel,
                                         input logic [31:0] alu,
                                         input logic [31:0] rdata,
                                         input logic [31:0] pc);
    logic [31:0] r;
    case (sel)
      WB_MEM:  r = rdata;
      WB_PC:   r = pc;
      default: r = alu;  // WB_ALU and the unused code 11
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register with capture/bubble control.
//   Ports: clk, rst_n (async active-low), capture, regwr_i/regdst_i/wdata_i in,
//          regwr_o/regdst_o/wdata_o out. One cycle from capture to output.
//   A bubble (capture=0) clears the write enable and holds dst/data.
module mem_wb_reg #(
  parameter int REGDST_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                capture,
  input  logic                regwr_i,
  input  logic [REGDST_W-1:0] regdst_i,
  input  logic [31:0]         wdata_i,
  output logic                regwr_o,
  output logic [REGDST_W-1:0] regdst_o,
  output logic [31:0]         wdata_o
);

  logic                regwr_q, regwr_d;
  logic [REGDST_W-1:0] regdst_q, regdst_d;
  logic [31:0]         wdata_q, wdata_d;

  always_comb begin
    regwr_d  = 1'b0;
    regdst_d = regdst_q;
    wdata_d  = wdata_q;
    if (capture) begin
      regwr_d  = regwr_i;
      regdst_d = regdst_i;
      wdata_d  = wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwr_q  <= 1'b0;
      regdst_q <= '0;
      wdata_q  <= '0;
    end else begin
      regwr_q  <= regwr_d;
      regdst_q <= regdst_d;
      wdata_q  <= wdata_d;
    end
  end

  assign regwr_o  = regwr_q;
  assign regdst_o = regdst_q;
  assign wdata_o  = wdata_q;

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the 5-stage MIPS pipeline. Issues the data-memory
//   access on a req/ack bus, stalls upstream while it is outstanding, aborts after
//   TIMEOUT wait cycles, and registers the selected write-back value into MEM/WB.
// Ports: clk, reset (async active-low); EX/MEM inputs i*; dmem_* bus; mem_stall;
//   bus_err (1-cycle pulse); MEM/WB outputs oRegWr/oRegDst/oWriteData.
// Option: define MEM_ALIGN_CHECK_EN to reject accesses with iALUResult[1:0]!=0.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int REGDST_W  = 32,
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         iNextPC,
  input  logic                iRegWr,
  input  logic                iMemWr,
  input  logic                iMemRd,
  input  logic [1:0]          iMemToReg,
  input  logic [31:0]         iALUResult,
  input  logic [31:0]         iReadData2,
  input  logic [REGDST_W-1:0] iRegDst,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [31:0]         dmem_addr,
  output logic [31:0]         dmem_wdata,
  input  logic [31:0]         dmem_rdata,
  input  logic                dmem_ack,
  output logic                mem_stall,
  output logic                bus_err,
  output logic                oRegWr,
  output logic [REGDST_W-1:0] oRegDst,
  output logic [31:0]         oWriteData
);

  localparam logic [TIMEOUT_W-1:0] TO_VAL = TIMEOUT_W'(TIMEOUT);

  state_t               state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 bus_err_q, bus_err_d;
  logic                 access, misalign, abort, capture, stall;

  assign access = iMemRd | iMemWr;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = access & (iALUResult[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign abort = (state_q == S_WAIT) & ~dmem_ack & (cnt_q == TO_VAL);

  // Gating with reset makes req/stall fall the instant reset asserts, even
  // though the frozen upstream still presents the access.
  assign dmem_req   = access & ~misalign & ~abort & reset;
  assign dmem_we    = iMemWr;
  assign dmem_addr  = iALUResult;
  assign dmem_wdata = iReadData2;
  assign mem_stall  = stall & reset;
  assign bus_err    = bus_err_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    stall     = 1'b0;
    bus_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (misalign) begin
          bus_err_d = 1'b1;           // no request, bubble, no stall
        end else if (!access || dmem_ack) begin
          capture = 1'b1;             // non-memory op or zero-wait access
        end else begin
          state_d = S_WAIT;
          cnt_d   = TIMEOUT_W'(1);
          stall   = 1'b1;
        end
      end
      S_WAIT: begin
        if (dmem_ack) begin
          capture = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == TO_VAL) begin
          // Abort: release the pipeline past the faulting instruction.
          bus_err_d = 1'b1;
          state_d   = S_IDLE;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
          stall = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  mem_wb_reg #(.REGDST_W(REGDST_W)) u_mem_wb (
    .clk      (clk),
    .rst_n    (reset),
    .capture  (capture),
    .regwr_i  (iRegWr),
    .regdst_i (iRegDst),
    .wdata_i  (wb_mux(iMemToReg, iALUResult, dmem_rdata, iNextPC)),
    .regwr_o  (oRegWr),
    .regdst_o (oRegDst),
    .wdata_o  (oWriteData)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: self-checking bench for mem_access_stage (TIMEOUT=4).
//   Single-cycle vectors come from a table; multi-cycle waits, timeout and
//   reset-in-WAIT are hand-built step sequences sharing the same step task.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] iNextPC, iALUResult, iReadData2, iRegDst, dmem_rdata;
  logic        iRegWr, iMemWr, iMemRd, dmem_ack;
  logic [1:0]  iMemToReg;
  logic        dmem_req, dmem_we, mem_stall, bus_err, oRegWr;
  logic [31:0] dmem_addr, dmem_wdata, oRegDst, oWriteData;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.REGDST_W(32), .TIMEOUT(4), .TIMEOUT_W(8)) dut (
    .clk(clk), .reset(reset),
    .iNextPC(iNextPC), .iRegWr(iRegWr), .iMemWr(iMemWr), .iMemRd(iMemRd),
    .iMemToReg(iMemToReg), .iALUResult(iALUResult), .iReadData2(iReadData2),
    .iRegDst(iRegDst),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .mem_stall(mem_stall), .bus_err(bus_err),
    .oRegWr(oRegWr), .oRegDst(oRegDst), .oWriteData(oWriteData)
  );

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        rw, mw, mr;
    logic [1:0]  mtr;
    logic [31:0] alu, rd2, dst, rdata;
    logic        ack;
    logic        e_req, e_we, e_stall, e_wr;
    logic [31:0] e_dst, e_wd;
    logic        e_berr;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [31:0] dst, wd;
    logic        berr;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[10];

  function automatic vec_t mkv(string n, logic [31:0] pc, logic rw, logic mw, logic mr,
                               logic [1:0] mtr, logic [31:0] alu, logic [31:0] rd2,
                               logic [31:0] dst, logic [31:0] rdata, logic ack,
                               logic er, logic ew, logic es, logic ewr,
                               logic [31:0] edst, logic [31:0] ewd, logic eb);
    vec_t v;
    v.name = n; v.pc = pc; v.rw = rw; v.mw = mw; v.mr = mr; v.mtr = mtr;
    v.alu = alu; v.rd2 = rd2; v.dst = dst; v.rdata = rdata; v.ack = ack;
    v.e_req = er; v.e_we = ew; v.e_stall = es; v.e_wr = ewr;
    v.e_dst = edst; v.e_wd = ewd; v.e_berr = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    iNextPC = v.pc; iRegWr = v.rw; iMemWr = v.mw; iMemRd = v.mr;
    iMemToReg = v.mtr; iALUResult = v.alu; iReadData2 = v.rd2;
    iRegDst = v.dst; dmem_rdata = v.rdata; dmem_ack = v.ack;
  endtask

  // One pipeline cycle: drive, check bus/stall mid-cycle, check MEM/WB after the edge.
  task automatic step(input vec_t v);
    exp_t e;
    drive(v);
    @(negedge clk);
    chk({v.name, ".req"},   {31'd0, dmem_req},  {31'd0, v.e_req});
    chk({v.name, ".we"},    {31'd0, dmem_we},   {31'd0, v.e_we});
    chk({v.name, ".stall"}, {31'd0, mem_stall}, {31'd0, v.e_stall});
    chk({v.name, ".addr"},  dmem_addr,  v.alu);
    chk({v.name, ".wdata"}, dmem_wdata, v.rd2);
    e.wr = v.e_wr; e.dst = v.e_dst; e.wd = v.e_wd; e.berr = v.e_berr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL %s.sb: scoreboard empty", v.name);
    end else begin
      e = sb.pop_front();
      chk({v.name, ".oRegWr"},     {31'd0, oRegWr},  {31'd0, e.wr});
      chk({v.name, ".oRegDst"},    oRegDst,          e.dst);
      chk({v.name, ".oWriteData"}, oWriteData,       e.wd);
      chk({v.name, ".bus_err"},    {31'd0, bus_err}, {31'd0, e.berr});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    reset = 1'b0;
    drive(mkv("nop", 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    chk("rst.oRegWr",     {31'd0, oRegWr},    32'd0);
    chk("rst.oRegDst",    oRegDst,            32'd0);
    chk("rst.oWriteData", oWriteData,         32'd0);
    chk("rst.bus_err",    {31'd0, bus_err},   32'd0);
    chk("rst.stall",      {31'd0, mem_stall}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    //               name    pc      rw mw mr mtr    alu           rd2    dst rdata         ack  req we st wr dst wd            be
    tbl[0] = mkv("alu",   32'h4,   1, 0, 0, 2'b00, 32'h1234, 0, 5, 0, 0,   0, 0, 0, 1, 5, 32'h1234, 0);
    tbl[1] = mkv("ld0",   32'h8,   1, 0, 1, 2'b01, 32'h100, 0, 8, 32'hDEADBEEF, 1, 1, 0, 0, 1, 8, 32'hDEADBEEF, 0);
    tbl[2] = mkv("link",  32'h404, 1, 0, 0, 2'b10, 32'h999, 0, 31, 0, 0,  0, 0, 0, 1, 31, 32'h404, 0);
    tbl[3] = mkv("sel11", 32'h8,   1, 0, 0, 2'b11, 32'hCAFE, 0, 7, 32'h1, 0, 0, 0, 0, 1, 7, 32'hCAFE, 0);
    tbl[4] = mkv("nowr",  32'h0,   0, 0, 0, 2'b00, 32'h55, 0, 3, 0, 0,    0, 0, 0, 0, 3, 32'h55, 0);
    tbl[5] = mkv("st0",   32'h0,   0, 1, 0, 2'b00, 32'h200, 32'h77, 0, 0, 1, 1, 1, 0, 0, 0, 32'h200, 0);
    tbl[6] = mkv("rdwr",  32'h0,   0, 1, 1, 2'b00, 32'h204, 32'h88, 2, 0, 1, 1, 1, 0, 0, 2, 32'h204, 0);
    tbl[7] = mkv("ackidle", 32'h0, 1, 0, 0, 2'b00, 32'h42, 0, 4, 32'hFFFF, 1, 0, 0, 0, 1, 4, 32'h42, 0);
`ifdef MEM_ALIGN_CHECK_EN
    tbl[8] = mkv("mis",   32'h0,   1, 0, 1, 2'b01, 32'h102, 0, 6, 32'h0BADF00D, 1, 0, 0, 0, 0, 4, 32'h42, 1);
`else
    tbl[8] = mkv("mis",   32'h0,   1, 0, 1, 2'b01, 32'h102, 0, 6, 32'h0BADF00D, 1, 1, 0, 0, 1, 6, 32'h0BADF00D, 0);
`endif
    tbl[9] = mkv("after", 32'h0,   1, 0, 0, 2'b00, 32'h10, 0, 1, 0, 0,    0, 0, 0, 1, 1, 32'h10, 0);
    for (int i = 0; i < 10; i++) step(tbl[i]);

    // Store acked after three stall cycles; MEM/WB holds dst=1/data=0x10 meanwhile.
    for (int c = 0; c < 4; c++) begin
      v = mkv($sformatf("st3w%0d", c), 0, 0, 1, 0, 2'b00, 32'h104, 32'hABCD, 0, 0, (c == 3),
              1, 1, (c != 3), 0, (c == 3) ? 32'd0 : 32'd1, (c == 3) ? 32'h104 : 32'h10, 0);
      step(v);
    end

    // Load acked after two stall cycles.
    for (int c = 0; c < 3; c++) begin
      v = mkv($sformatf("ld2w%0d", c), 0, 1, 0, 1, 2'b01, 32'h300, 0, 12, 32'hA5A5A5A5, (c == 2),
              1, 0, (c != 2), (c == 2), (c == 2) ? 32'd12 : 32'd0,
              (c == 2) ? 32'hA5A5A5A5 : 32'h104, 0);
      step(v);
    end

    // Load never acked: four stall cycles, then abort with one bus_err pulse.
    for (int c = 0; c < 5; c++) begin
      v = mkv($sformatf("to%0d", c), 0, 1, 0, 1, 2'b01, 32'h400, 0, 13, 32'h1, 0,
              (c != 4), 0, (c != 4), 0, 12, 32'hA5A5A5A5, (c == 4));
      step(v);
    end
    step(mkv("to_next", 0, 1, 0, 0, 2'b00, 32'h20, 0, 2, 0, 0, 0, 0, 0, 1, 2, 32'h20, 0));

    // Ack arriving on the last permitted wait cycle is still a success.
    for (int c = 0; c < 5; c++) begin
      v = mkv($sformatf("tolast%0d", c), 0, 1, 0, 1, 2'b01, 32'h500, 0, 14, 32'h5A, (c == 4),
              1, 0, (c != 4), (c == 4), (c == 4) ? 32'd14 : 32'd2,
              (c == 4) ? 32'h5A : 32'h20, 0);
      step(v);
    end

    // Reset asserted while waiting.
    for (int c = 0; c < 2; c++) begin
      v = mkv($sformatf("rw%0d", c), 0, 1, 0, 1, 2'b01, 32'h600, 0, 15, 32'h9, 0,
              1, 0, 1, 0, 14, 32'h5A, 0);
      step(v);
    end
    #2;
    reset = 1'b0;
    #1;
    chk("rstw.req",        {31'd0, dmem_req},  32'd0);
    chk("rstw.stall",      {31'd0, mem_stall}, 32'd0);
    chk("rstw.oRegWr",     {31'd0, oRegWr},    32'd0);
    chk("rstw.oRegDst",    oRegDst,            32'd0);
    chk("rstw.oWriteData", oWriteData,         32'd0);
    chk("rstw.bus_err",    {31'd0, bus_err},   32'd0);
    drive(mkv("nop", 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    step(mkv("postrst", 0, 1, 0, 0, 2'b00, 32'h30, 0, 3, 0, 0, 0, 0, 0, 1, 3, 32'h30, 0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
